truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
// Self-test controller for the 3-input / 2-output gate block (inputs a,b,c; outputs x,y).
// On a start pulse it applies all 8 input vectors in order and waits a settle window for each.
// It then samples x,y and compares them against the golden function x = ~(c ^ (a&b)), y = a&b.
// Reports error count, first failing vector and pass/fail; it sits between the board
// buttons/LEDs and the gate block under test.
// PARAMETERS
// SETTLE_CYCLES  2  cycles each vector is driven before sampling; legal range 1..15
// STOP_ON_FAIL   0  1: abort the sweep at the first mismatch; 0: run all 8 vectors
// PORTS
// clk             in   1  system clock, rising-edge
// rst             in   1  synchronous, active-high reset
// start           in   1  level sampled each cycle; accepted only in IDLE
// dut_a           out  1  stimulus a to gate block (vector bit 2)
// dut_b           out  1  stimulus b (vector bit 1)
// dut_c           out  1  stimulus c (vector bit 0)
// dut_x           in   1  gate block output x
// dut_y           in   1  gate block output y
// busy            out  1  high in SETTLE and SAMPLE states
// done            out  1  one-cycle pulse when a sweep ends (normal or aborted)
// pass            out  1  valid from done onward: 1 iff err_count==0; held until next start
// err_count       out  4  mismatching vectors in the last sweep (0..8)
// fail_valid      out  1  at least one mismatch recorded this sweep
// first_fail_vec  out  3  {a,b,c} of the first mismatch; 0 when fail_valid==0
// BEHAVIOUR
// - Reset: state=IDLE; dut_a/b/c=0; busy=0, done=0, pass=0, err_count=0, fail_valid=0,
//   first_fail_vec=0; vector idx=0; settle cnt=0. Reset mid-sweep aborts at once, no done pulse.
// - FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
// - IDLE: start=1 -> clear err_count/fail_valid/first_fail_vec/pass, idx=0, cnt=0 -> SETTLE.
// - SETTLE: drive {dut_a,dut_b,dut_c}=idx; cnt++; when cnt==SETTLE_CYCLES-1 -> SAMPLE.
// - SAMPLE: keep driving idx; compare {dut_x,dut_y} with golden(idx).
//   On mismatch: err_count++; if fail_valid==0, set first_fail_vec=idx and fail_valid=1.
//   Exit: idx==7, or (mismatch && STOP_ON_FAIL) -> DONE; else idx++, cnt=0 -> SETTLE.
// - DONE: done=1 for exactly this cycle; pass=(err_count==0) after the final update;
//   dut_a/b/c return to 0 -> IDLE.
// - Timing: if start is accepted at edge k, vector i is sampled in cycle k+(i+1)*(SETTLE_CYCLES+1).
//   done is high in cycle k+8*(SETTLE_CYCLES+1)+1. With the default of 2, done is at k+25.
// - start is ignored in SETTLE, SAMPLE and DONE; it is not queued.
//   start held high re-triggers on the first IDLE cycle after DONE (back-to-back sweeps).
// - err_count saturates naturally at 8 (4-bit counter, 8 vectors max); no wrap.
// - Golden table {a,b,c} -> {x,y}: 0->10 1->00 2->10 3->00 4->10 5->00 6->01 7->11.
// - Results (pass, err_count, fail_valid, first_fail_vec) hold their value in IDLE until the next accepted start.
// TESTING
// 1 Correct gate model, SETTLE_CYCLES=2, start pulse at edge k -> dut vectors 0..7 in order,
//   done at k+25, pass=1, err_count=0, fail_valid=0.
// 2 Model with y stuck-at-0 -> only vectors 6 and 7 fail -> err_count=2, first_fail_vec=3'b110, pass=0.
// 3 Same fault, STOP_ON_FAIL=1 -> done one cycle after vector 6 is sampled (k+22),
//   err_count=1, first_fail_vec=6.
// 4 rst asserted during vector 3 SETTLE -> next cycle IDLE, all outputs 0, no done pulse;
//   a new start then completes a full sweep.
// 5 start pulsed during busy -> ignored: exactly one done per sweep and timing unchanged.
//   start held high -> two sweeps, with the second SETTLE beginning 2 cycles after the first done.
// 6 SETTLE_CYCLES=1 with x inverted in the model -> all 8 vectors fail, err_count=8,
//   first_fail_vec=0, done at k+17.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and the gate block / board I/O.
// The master side is the sequencer: it drives stimulus and status, and
// receives start and the gate block's x/y outputs.
interface truth_table_sequencer_if;
  logic       start;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic       dut_x;
  logic       dut_y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail_vec;

  modport master (
    input  start, dut_x, dut_y,
    output dut_a, dut_b, dut_c, busy, done, pass, err_count,
           fail_valid, first_fail_vec
  );

  modport slave (
    output start, dut_x, dut_y,
    input  dut_a, dut_b, dut_c, busy, done, pass, err_count,
           fail_valid, first_fail_vec
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Self-test sweep for the 3-in/2-out gate block: drives all 8 {a,b,c}
// vectors, lets each settle, samples {x,y} against the golden function
// x = ~(c ^ (a&b)), y = a&b, and reports error count / first failure / pass.
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,   // 1..15
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input logic                    clk_i,
  input logic                    rst_i,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic [2:0] vec_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic       fail_valid_q;
  logic [2:0] first_fail_q;

  logic       mismatch;
  logic [3:0] err_d;

  function automatic logic [1:0] golden(input logic [2:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    return {~(c ^ (a & b)), a & b};
  endfunction

  // Compare the gate block against the golden table for the vector under test.
  always_comb begin
    mismatch = ({bus.dut_x, bus.dut_y} != golden(idx_q));
    err_d    = err_q + {3'b000, mismatch};
  end

  // Sweep FSM; every output is a register updated on the transition into
  // the state in which it must be visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 4'd0;
      vec_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 4'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            err_q        <= 4'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 3'd0;
            pass_q       <= 1'b0;
            idx_q        <= 3'd0;
            cnt_q        <= 4'd0;
            vec_q        <= 3'd0;
            busy_q       <= 1'b1;
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          vec_q <= idx_q;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) state_q <= SAMPLE;
        end
        SAMPLE: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            first_fail_q <= idx_q;
            fail_valid_q <= 1'b1;
          end
          if (idx_q == 3'd7 || (mismatch && STOP_ON_FAIL)) begin
            // pass uses the post-update count so it is valid alongside done
            pass_q  <= (err_d == 4'd0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            vec_q   <= 3'd0;
            state_q <= DONE;
          end else begin
            // present the next vector now so its settle window is full length
            idx_q   <= idx_q + 3'd1;
            vec_q   <= idx_q + 3'd1;
            cnt_q   <= 4'd0;
            state_q <= SETTLE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dut_a          = vec_q[2];
  assign bus.dut_b          = vec_q[1];
  assign bus.dut_c          = vec_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail_vec = first_fail_q;

endmodule
